// File: rtl/asic_cfg_pkg.sv
// Shared definitions for the ASIC-side configuration responder.
//   - default static/dynamic register sizes
//   - depth of the input synchronisers
//   - responder FSM state encoding
package asic_cfg_pkg;

    localparam int unsigned SIZESRSTAT_DEF = 88;
    localparam int unsigned SIZESRDYN_DEF  = 16;
    localparam int unsigned SYNC_STAGES    = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StCommit = 2'd2
    } state_e;

endpackage

// File: rtl/asic_cfg_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with optional edge detection.
// Ports:
//   CLK       in   system clock
//   RST       in   synchronous reset, active-high
//   async_in  in   asynchronous input pin
//   sync_out  out  synchronised level (last synchroniser stage)
//   rise_out  out  one-CLK pulse on a synchronised rising edge (0 when EDGE_EN=0)
//   fall_out  out  one-CLK pulse on a synchronised falling edge (0 when EDGE_EN=0)
module asic_cfg_sync_edge
    import asic_cfg_pkg::*;
#(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic sync_out,
    output logic rise_out,
    output logic fall_out
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    if (EDGE_EN) begin : g_edge
        // Extra stage holds the previous synchronised level for edge compare.
        logic dly_q, dly_d;

        always_comb begin
            dly_d = sync_out;
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                dly_q <= 1'b0;
            end else begin
                dly_q <= dly_d;
            end
        end

        assign rise_out = sync_out & ~dly_q;
        assign fall_out = ~sync_out & dly_q;
    end else begin : g_no_edge
        assign rise_out = 1'b0;
        assign fall_out = 1'b0;
    end

endmodule

// File: rtl/asic_cfg_responder.sv
// ASIC-side end of the CLK/SEL/MOSI/MISO configuration link, clocked entirely by CLK.
// Oversamples sclk_in/sel_in/mosi_in, deserialises frames into STATCNF (SIZESRSTAT bits)
// or DYNCNF (SIZESRDYN bits) depending on frame length, and drives miso_out.
// Ports:
//   CLK        in   system clock (>= 8x serial clock)
//   RST        in   synchronous reset, active-high
//   sclk_in    in   serial clock (async)
//   sel_in     in   frame select, active-high (async)
//   mosi_in    in   serial data in (async)
//   miso_out   out  serial readback
//   STATCNF    out  latched static configuration
//   DYNCNF     out  latched dynamic configuration
//   stat_upd   out  one-CLK pulse when STATCNF is written
//   dyn_upd    out  one-CLK pulse when DYNCNF is written
//   frame_err  out  one-CLK pulse for an illegal frame length
// Build option ASIC_CFG_READBACK_EN:
//   defined   - miso_out shifts out {DYNCNF, STATCNF} captured at frame start, MSB first
//   undefined - miso_out is the shift register MSB (plain daisy-chain output)
module asic_cfg_responder
    import asic_cfg_pkg::*;
#(
    parameter int unsigned           SIZESRSTAT   = SIZESRSTAT_DEF,
    parameter int unsigned           SIZESRDYN    = SIZESRDYN_DEF,
    parameter logic [SIZESRSTAT-1:0] STAT_RST_VAL = '0,
    parameter logic [SIZESRDYN-1:0]  DYN_RST_VAL  = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sclk_in,
    input  logic                  sel_in,
    input  logic                  mosi_in,
    output logic                  miso_out,
    output logic [SIZESRSTAT-1:0] STATCNF,
    output logic [SIZESRDYN-1:0]  DYNCNF,
    output logic                  stat_upd,
    output logic                  dyn_upd,
    output logic                  frame_err
);

    // Counter must reach SIZESRSTAT+1 so that over-long frames stay distinguishable.
    localparam int unsigned       CNT_W    = $clog2(SIZESRSTAT + 2);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(SIZESRSTAT + 1);
    localparam logic [CNT_W-1:0]  CNT_STAT = CNT_W'(SIZESRSTAT);
    localparam logic [CNT_W-1:0]  CNT_DYN  = CNT_W'(SIZESRDYN);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic sclk_rise, sclk_fall, sel_rise, sel_fall, mosi_s;
    logic sclk_lvl_unused, sel_lvl_unused, mosi_rise_unused, mosi_fall_unused;

    asic_cfg_sync_edge #(.EDGE_EN(1'b1)) u_sync_sclk (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (sclk_in),
        .sync_out (sclk_lvl_unused),
        .rise_out (sclk_rise),
        .fall_out (sclk_fall)
    );

    asic_cfg_sync_edge #(.EDGE_EN(1'b1)) u_sync_sel (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (sel_in),
        .sync_out (sel_lvl_unused),
        .rise_out (sel_rise),
        .fall_out (sel_fall)
    );

    asic_cfg_sync_edge #(.EDGE_EN(1'b0)) u_sync_mosi (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (mosi_in),
        .sync_out (mosi_s),
        .rise_out (mosi_rise_unused),
        .fall_out (mosi_fall_unused)
    );

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SIZESRSTAT-1:0]   sr_q, sr_d;
    logic [SIZESRSTAT-1:0]   stat_q, stat_d;
    logic [SIZESRDYN-1:0]    dyn_q, dyn_d;
    logic                    miso_q, miso_d;
    logic                    stat_upd_q, stat_upd_d;
    logic                    dyn_upd_q, dyn_upd_d;
    logic                    frame_err_q, frame_err_d;
`ifdef ASIC_CFG_READBACK_EN
    localparam int unsigned  RB_W = SIZESRSTAT + SIZESRDYN;
    logic [RB_W-1:0]         rb_q, rb_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        stat_d      = stat_q;
        dyn_d       = dyn_q;
        miso_d      = miso_q;
        stat_upd_d  = 1'b0;
        dyn_upd_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef ASIC_CFG_READBACK_EN
        rb_d        = rb_q;
`endif
        unique case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (sel_rise) begin
                    state_d = StShift;
                    cnt_d   = '0;
`ifdef ASIC_CFG_READBACK_EN
                    rb_d    = {dyn_q, stat_q};
`endif
                end
            end
            StShift: begin
                // A sel fall wins over a coincident sclk rise: that bit is dropped.
                if (sel_fall) begin
                    state_d = StCommit;
                end else if (sclk_rise) begin
                    sr_d = {sr_q[SIZESRSTAT-2:0], mosi_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                if (sclk_fall) begin
`ifdef ASIC_CFG_READBACK_EN
                    miso_d = rb_q[RB_W-1];
                    rb_d   = {rb_q[RB_W-2:0], 1'b0};
`else
                    miso_d = sr_q[SIZESRSTAT-1];
`endif
                end
            end
            StCommit: begin
                state_d = StIdle;
                miso_d  = 1'b0;
                if (cnt_q == CNT_DYN) begin
                    dyn_d     = sr_q[SIZESRDYN-1:0];
                    dyn_upd_d = 1'b1;
                end else if (cnt_q == CNT_STAT) begin
                    stat_d     = sr_q;
                    stat_upd_d = 1'b1;
                end else if (cnt_q != '0) begin
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sr_q        <= '0;
            stat_q      <= STAT_RST_VAL;
            dyn_q       <= DYN_RST_VAL;
            miso_q      <= 1'b0;
            stat_upd_q  <= 1'b0;
            dyn_upd_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef ASIC_CFG_READBACK_EN
            rb_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            stat_q      <= stat_d;
            dyn_q       <= dyn_d;
            miso_q      <= miso_d;
            stat_upd_q  <= stat_upd_d;
            dyn_upd_q   <= dyn_upd_d;
            frame_err_q <= frame_err_d;
`ifdef ASIC_CFG_READBACK_EN
            rb_q        <= rb_d;
`endif
        end
    end

    assign miso_out  = miso_q;
    assign STATCNF   = stat_q;
    assign DYNCNF    = dyn_q;
    assign stat_upd  = stat_upd_q;
    assign dyn_upd   = dyn_upd_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_asic_cfg_responder.sv
// Directed testbench for asic_cfg_responder: frames of legal and illegal length,
// commit latency, readback/daisy-chain miso behaviour and mid-frame reset.
module tb_asic_cfg_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        sclk_in = 1'b0;
    logic        sel_in = 1'b0;
    logic        mosi_in = 1'b0;
    logic        miso_out;
    logic [87:0] STATCNF;
    logic [15:0] DYNCNF;
    logic        stat_upd, dyn_upd, frame_err;

    int checks = 0;
    int failures = 0;

    // Bench-side expectations: configuration registers, shift register, readback.
    logic [87:0]  e_stat = '0;
    logic [15:0]  e_dyn = '0;
    logic [87:0]  m_sr = '0;
    logic [103:0] m_rb = '0;

    int tot_dyn = 0, tot_stat = 0, tot_err = 0;

    asic_cfg_responder dut (
        .CLK       (CLK),
        .RST       (RST),
        .sclk_in   (sclk_in),
        .sel_in    (sel_in),
        .mosi_in   (mosi_in),
        .miso_out  (miso_out),
        .STATCNF   (STATCNF),
        .DYNCNF    (DYNCNF),
        .stat_upd  (stat_upd),
        .dyn_upd   (dyn_upd),
        .frame_err (frame_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (dyn_upd)   tot_dyn++;
        if (stat_upd)  tot_stat++;
        if (frame_err) tot_err++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One serial bit: data set, sclk high for 'half' CLK, low for 'half' CLK, then miso checked.
    task automatic bit_xfer(input logic b, input int half, input string tag);
        logic exp_miso;
        mosi_in = b;
        tick(1);
        sclk_in = 1'b1;
        m_sr = {m_sr[86:0], b};
        tick(half);
        sclk_in = 1'b0;
`ifdef ASIC_CFG_READBACK_EN
        exp_miso = m_rb[103];
        m_rb = {m_rb[102:0], 1'b0};
`else
        exp_miso = m_sr[87];
`endif
        tick(half);
        check(tag, miso_out, exp_miso);
    endtask

    task automatic frame_start();
        sel_in = 1'b1;
        m_rb = {e_dyn, e_stat};
        tick(4);
    endtask

    // kind: 0 = no action, 1 = dynamic write, 2 = static write, 3 = length error
    task automatic send_frame(input string name, input logic [87:0] data, input int nbits,
                              input int half, input int kind);
        int n_dyn, n_stat, n_err, pos;
        frame_start();
        for (int i = nbits - 1; i >= 0; i--) begin
            bit_xfer(data[i], half, $sformatf("%s miso bit%0d", name, i));
        end
        sel_in = 1'b0;
        n_dyn = 0; n_stat = 0; n_err = 0; pos = 0;
        for (int c = 1; c <= 6; c++) begin
            tick(1);
            if (dyn_upd)   begin n_dyn++;  pos = c; end
            if (stat_upd)  begin n_stat++; pos = c; end
            if (frame_err) begin n_err++;  pos = c; end
        end
        check({name, " dyn_upd count"}, n_dyn, (kind == 1) ? 1 : 0);
        check({name, " stat_upd count"}, n_stat, (kind == 2) ? 1 : 0);
        check({name, " frame_err count"}, n_err, (kind == 3) ? 1 : 0);
        if (kind != 0) check({name, " pulse latency"}, pos, 4);
        if (kind == 1) e_dyn = m_sr[15:0];
        if (kind == 2) e_stat = m_sr;
        check({name, " miso idle"}, miso_out, 1'b0);
        tick(4);
    endtask

    initial begin
        // Reset state
        tick(5);
        check("reset STATCNF", STATCNF, 88'h0);
        check("reset DYNCNF", DYNCNF, 16'h0);
        check("reset miso", miso_out, 1'b0);
        check("reset pulses", {stat_upd, dyn_upd, frame_err}, 3'b000);
        RST = 1'b0;
        tick(4);

        // 16-bit dynamic write
        send_frame("dyn4321", 88'h4321, 16, 4, 1);
        check("dyn4321 DYNCNF", DYNCNF, 16'h4321);
        check("dyn4321 STATCNF", STATCNF, 88'h0);

        // 88-bit static write
        send_frame("stat88", 88'hFEDCBA9876543210012345, 88, 8, 2);
        check("stat88 STATCNF", STATCNF, 88'hFEDCBA9876543210012345);
        check("stat88 DYNCNF", DYNCNF, 16'h4321);

        // 20-bit frame: illegal length
        send_frame("len20", 88'hABCDE, 20, 4, 3);
        check("len20 DYNCNF", DYNCNF, 16'h4321);
        check("len20 STATCNF", STATCNF, 88'hFEDCBA9876543210012345);

        // sel pulse without sclk
        send_frame("empty", 88'h0, 0, 4, 0);
        check("empty DYNCNF", DYNCNF, 16'h4321);
        check("empty STATCNF", STATCNF, 88'hFEDCBA9876543210012345);

        // Reset after 40 bits of an 88-bit frame
        frame_start();
        for (int i = 87; i >= 48; i--) begin
            bit_xfer(i[0], 4, $sformatf("abort miso bit%0d", i));
        end
        tot_dyn = 0; tot_stat = 0; tot_err = 0;
        RST = 1'b1;
        sel_in = 1'b0;
        tick(5);
        RST = 1'b0;
        tick(6);
        e_dyn = '0; e_stat = '0; m_sr = '0;
        check("abort STATCNF", STATCNF, 88'h0);
        check("abort DYNCNF", DYNCNF, 16'h0);
        check("abort miso", miso_out, 1'b0);
        check("abort no pulses", tot_dyn + tot_stat + tot_err, 0);

        send_frame("dynABCD", 88'hABCD, 16, 4, 1);
        check("dynABCD DYNCNF", DYNCNF, 16'hABCD);
        check("dynABCD STATCNF", STATCNF, 88'h0);

        // Back-to-back dynamic frames; daisy-chain miso stays 0 until 88 bits passed
        send_frame("dynAAAA", 88'hAAAA, 16, 4, 1);
        check("dynAAAA DYNCNF", DYNCNF, 16'hAAAA);
        send_frame("dyn5555", 88'h5555, 16, 4, 1);
        check("dyn5555 DYNCNF", DYNCNF, 16'h5555);
        check("dyn5555 STATCNF", STATCNF, 88'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/asic_cfg_responder.md
Name: asic_cfg_responder

Overview:
- ASIC-side end of the CLK/SEL/MOSI/MISO configuration link.
- Runs entirely on the 16 MHz system clock and oversamples the incoming serial clock.
- Deserialises MOSI frames into the static (STATCNF) and dynamic (DYNCNF) configuration registers and serialises the current configuration back on MISO.
- Used as the analog-chip stand-in on the second FPGA, so the bridge can check its writes end to end.

Parameters:
- SIZESRSTAT, 88, static register length in bits (frame length for a static write).
- SIZESRDYN, 16, dynamic register length in bits (frame length for a dynamic write). Must be less than SIZESRSTAT.
- STAT_RST_VAL, {SIZESRSTAT{1'b0}}, STATCNF reset value.
- DYN_RST_VAL, {SIZESRDYN{1'b0}}, DYNCNF reset value.

Ports:
- CLK  in  1  system clock, 16 MHz. Must be at least 8x the serial clock.
- RST  in  1  synchronous reset, active-high.
- sclk_in  in  1  serial clock from the bridge; asynchronous to CLK.
- sel_in  in  1  frame select, active-high; asynchronous.
- mosi_in  in  1  serial data in; asynchronous.
- miso_out  out  1  serial readback data.
- STATCNF  out  SIZESRSTAT  latched static configuration.
- DYNCNF  out  SIZESRDYN  latched dynamic configuration.
- stat_upd  out  1  one-CLK pulse when STATCNF is updated.
- dyn_upd  out  1  one-CLK pulse when DYNCNF is updated.
- frame_err  out  1  one-CLK pulse when a frame has an illegal length.

Behaviour:
- Reset:
  - STATCNF=STAT_RST_VAL, DYNCNF=DYN_RST_VAL.
  - miso_out=0; stat_upd, dyn_upd and frame_err =0.
  - State=IDLE; bit counter=0; shift register=0; synchroniser flops=0.
- Input synchronisation:
  - sclk_in, sel_in and mosi_in each pass through 2 flops.
  - A third flop on sclk and on sel provides edge detection.
  - Every serial event is therefore seen 3 CLK after the pin changes.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE -> SHIFT on synchronised sel rise. Counter cleared; readback register loaded with {DYNCNF, STATCNF}, MSB first.
  - SHIFT, on sclk rise: shift register <= {sr[SIZESRSTAT-2:0], mosi_s}. Counter increments and saturates at SIZESRSTAT+1.
  - SHIFT, on sclk fall: miso_out <= readback MSB, then the readback register shifts left and fills with 0.
  - SHIFT -> COMMIT on synchronised sel fall.
  - If an sclk rise and a sel fall are detected in the same CLK, the sclk rise is discarded.
  - COMMIT (one cycle), then IDLE. The counter value selects the action:
    - SIZESRDYN: DYNCNF <= sr[SIZESRDYN-1:0], dyn_upd=1.
    - SIZESRSTAT: STATCNF <= sr, stat_upd=1.
    - 0: no action, no error.
    - any other value: frame_err=1, both registers unchanged.
- Latency: register update and pulse appear 1 CLK after the synchronised sel fall, i.e. 4 CLK after the pin falls.
- miso_out returns to 0 in IDLE.
- In SHIFT, miso_out holds its value between sclk falls.
- RST asserted mid-frame aborts the frame: no commit, reset values applied.
- Extra bits beyond SIZESRSTAT still shift in, but the saturated counter forces frame_err.

Optional Feature:
- Macro ASIC_CFG_READBACK_EN.
- Defined: miso_out behaves as described above.
- Undefined: no readback register is built; miso_out = last bit shifted out of the shift register (sr[SIZESRSTAT-1]), updated on sclk fall. This is the plain daisy-chain SDO behaviour.

Decomposition:
- Shared package asic_cfg_pkg holds:
  - state enum (IDLE/SHIFT/COMMIT);
  - default sizes 88 and 16;
  - SYNC_STAGES=2.
- One natural sub-module: asic_cfg_sync_edge, the 2-flop synchroniser plus rise/fall detector. Instantiated three times (no edges needed for mosi).

Test Plan:
- Reset, then a 16-bit frame 16'h4321 at 2 MHz -> DYNCNF=16'h4321 and one dyn_upd pulse 4 CLK after the sel fall; STATCNF stays 0.
- An 88-bit frame 88'hFEDCBA9876543210012345 at 1 MHz -> STATCNF equals that value with one stat_upd pulse. miso_out during the frame carries the DYNCNF MSB first: 0100_0011_0010_0001 (16'h4321), then 72 zeros.
- A 20-bit frame -> frame_err pulse; DYNCNF and STATCNF unchanged; no upd pulses.
- sel pulse with no sclk edges -> no pulses, no error, registers unchanged.
- RST asserted after 40 bits of an 88-bit frame, then a fresh 16-bit 16'hABCD frame -> registers at reset values after RST; then DYNCNF=16'hABCD with no frame_err.
- Build without ASIC_CFG_READBACK_EN, send two consecutive 16-bit frames 16'hAAAA then 16'h5555 -> miso_out during the second frame matches sr bit 87 on each sclk fall; all 0 because sr was cleared until 88 bits had passed.
